generador_rampa: RTL and testbench

//  Upstream stage of the PWM comparator. Produces the free-running ramp count c[9:0]
//  and the glitch-free duty reference d[9:0] consumed by comparador (comp = f(c,d)).

---
 rtl/pwm_pkg.sv | 7 +
 rtl/divisor_reloj.sv | 16 +
 rtl/generador_rampa.sv | 42 ++++
 tb/tb_generador_rampa.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, reset top and count type for the ramp generator and comparador
package pwm_pkg;
  localparam int DEF_WIDTH   = 10;
  localparam int DEF_PRESC_W = 8;
  localparam int DEF_TOP_RST = 1023;
  typedef logic [DEF_WIDTH-1:0] count_t;
endpackage

// File: rtl/divisor_reloj.sv
// divisor_reloj: prescaler producing one step every presc+1 enabled clocks
module divisor_reloj #(
  parameter int PRESC_W = pwm_pkg::DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  output logic               step
);
  logic [PRESC_W-1:0] pcnt;
  assign step = en && pcnt == presc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pcnt <= '0;
    else if (en) pcnt <= step ? '0 : pcnt + 1'b1;
endmodule

// File: rtl/generador_rampa.sv
// generador_rampa: ramp counter with shadowed duty/top applied only at period wrap
module generador_rampa import pwm_pkg::*; #(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int PRESC_W = DEF_PRESC_W,
  parameter int TOP_RST = DEF_TOP_RST
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  input  logic [WIDTH-1:0]   top_in,
  input  logic [WIDTH-1:0]   duty_in,
  input  logic               duty_wr,
  output logic [WIDTH-1:0]   c,
  output logic [WIDTH-1:0]   d,
  output logic               tick,
  output logic               duty_pend
);
  logic step, wrap;
  logic [WIDTH-1:0] top_act, shadow;
  divisor_reloj #(.PRESC_W(PRESC_W)) u_div (
    .clk(clk), .rst_n(rst_n), .en(en), .presc(presc), .step(step)
  );
  assign wrap = step && c == top_act;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      c         <= '0;
      d         <= '0;
      tick      <= 1'b0;
      duty_pend <= 1'b0;
      shadow    <= '0;
      top_act   <= WIDTH'(TOP_RST);
    end else begin
      tick <= wrap;
      if (step) c <= wrap ? '0 : c + 1'b1;
      if (wrap) top_act <= top_in;
      if (wrap) d <= duty_wr ? duty_in : duty_pend ? shadow : d;
      if (wrap) duty_pend <= 1'b0;
      else if (duty_wr) duty_pend <= 1'b1;
      if (duty_wr && !wrap) shadow <= duty_in;
    end
endmodule

// File: tb/tb_generador_rampa.sv
// tb_generador_rampa: directed literal checks plus random stimulus against a cycle model
module tb_generador_rampa;
  import pwm_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, duty_wr = 1'b0;
  logic [7:0] presc = '0;
  count_t top_in = '0, duty_in = '0, c, d;
  logic tick, duty_pend;
  int checks = 0, failures = 0;
  int m_c, m_d, m_tick, m_pend, m_sh, m_top, m_pc;
  int n, tot, cs;
  generador_rampa dut (
    .clk(clk), .rst_n(rst_n), .en(en), .presc(presc), .top_in(top_in),
    .duty_in(duty_in), .duty_wr(duty_wr), .c(c), .d(d), .tick(tick), .duty_pend(duty_pend)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_c = 0; m_d = 0; m_tick = 0; m_pend = 0; m_sh = 0; m_top = DEF_TOP_RST; m_pc = 0;
  endtask
  task automatic model_cmp();
    chk("c", int'(c), m_c);
    chk("d", int'(d), m_d);
    chk("tick", int'(tick), m_tick);
    chk("duty_pend", int'(duty_pend), m_pend);
  endtask
  // one clock: model advances from the inputs held across the rising edge, outputs compared 1ns later
  task automatic cyc();
    bit stp, wr;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      stp = en && m_pc == int'(presc);
      if (en) m_pc = stp ? 0 : (m_pc + 1) % 256;
      wr = stp && m_c == m_top;
      m_tick = wr ? 1 : 0;
      if (stp) m_c = wr ? 0 : m_c + 1;
      if (wr) begin
        m_top = int'(top_in);
        if (duty_wr) m_d = int'(duty_in);
        else if (m_pend != 0) m_d = m_sh;
        m_pend = 0;
      end else if (duty_wr) begin
        m_sh = int'(duty_in);
        m_pend = 1;
      end
    end
    #1 model_cmp();
    @(negedge clk);
  endtask
  task automatic wait_tick(output int k);
    k = 0;
    do begin cyc(); k++; end while (!tick && k < 5000);
    if (!tick) chk("tick_timeout", k, -1);
  endtask
  task automatic wait_c(input int v);
    int k = 0;
    while (int'(c) != v && k < 3000) begin cyc(); k++; end
    if (int'(c) != v) chk("c_timeout", int'(c), v);
  endtask
  task automatic async_reset();
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_c", int'(c), 0);
    chk("rst_d", int'(d), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_pend", int'(duty_pend), 0);
    cyc();
    rst_n = 1'b1;
  endtask
  initial begin
    model_reset();
    @(negedge clk);
    cyc(); cyc();
    rst_n = 1'b1;
    chk("reset_c", int'(c), 0);
    chk("reset_pend", int'(duty_pend), 0);
    en = 1'b1; top_in = 10'd9;
    wait_tick(n);
    chk("first_period_top1023", n, 1024);
    chk("c_at_tick", int'(c), 0);
    wait_tick(n);
    chk("period_top9", n, 10);
    presc = 8'd3; top_in = 10'd4;
    wait_tick(n);
    chk("period_top9_presc3", n, 40);
    wait_tick(n);
    chk("period_top4_presc3", n, 20);
    tot = 0;
    repeat (6) begin cyc(); tot++; end
    cs = int'(c);
    en = 1'b0;
    repeat (7) begin cyc(); tot++; end
    chk("c_frozen", int'(c), cs);
    en = 1'b1;
    wait_tick(n);
    chk("period_stretched", tot + n, 27);
    presc = 8'd0; top_in = 10'd1023;
    wait_tick(n);
    wait_c(300);
    duty_in = 10'd725; duty_wr = 1'b1; cyc(); duty_wr = 1'b0;
    chk("pend_after_wr", int'(duty_pend), 1);
    chk("d_held", int'(d), 0);
    wait_tick(n);
    chk("d_at_wrap", int'(d), 725);
    chk("pend_cleared", int'(duty_pend), 0);
    wait_c(600);
    duty_in = 10'd300; duty_wr = 1'b1; cyc();
    duty_in = 10'd100; cyc(); duty_wr = 1'b0;
    chk("d_held2", int'(d), 725);
    wait_tick(n);
    chk("last_write_wins", int'(d), 100);
    wait_c(1023);
    duty_in = 10'd5; duty_wr = 1'b1; cyc(); duty_wr = 1'b0;
    chk("wrap_wr_d", int'(d), 5);
    chk("wrap_wr_pend", int'(duty_pend), 0);
    chk("wrap_wr_tick", int'(tick), 1);
    wait_c(500);
    top_in = 10'd3;
    wait_tick(n);
    chk("top_change_deferred", n, 524);
    wait_tick(n);
    chk("period_top3", n, 4);
    top_in = 10'd0;
    wait_tick(n);
    repeat (4) begin
      cyc();
      chk("top0_c", int'(c), 0);
      chk("top0_tick", int'(tick), 1);
    end
    top_in = 10'd9;
    repeat (6) cyc();
    duty_in = 10'd77; duty_wr = 1'b1; cyc(); duty_wr = 1'b0;
    chk("pre_reset_c", int'(c), 6);
    async_reset();
    for (int i = 0; i < 3000; i++) begin
      en = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 49) == 0) presc = 8'($urandom_range(0, 3));
      top_in = ($urandom_range(0, 15) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 12));
      duty_wr = $urandom_range(0, 5) == 0;
      duty_in = 10'($urandom);
      if ($urandom_range(0, 299) == 0) async_reset();
      else cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
